// File: rtl/axi_wr_slave.sv
// AXI write-channel slave backed by a word-wide internal memory with a
// single-cycle backdoor read port. One outstanding burst; INCR only.
module axi_wr_slave #(
  parameter int PID_WIDTH     = 4,
  parameter int PADDR_WIDTH   = 32,
  parameter int PLENGTH_WIDTH = 8,
  parameter int PSIZE_WIDTH   = 3,
  parameter int PAWUSER_WIDTH = 4,
  parameter int PDATA_WIDTH   = 4,
  parameter int MEM_DEPTH     = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   awburst,
  input  logic [PID_WIDTH-1:0]         awid,
  input  logic [PADDR_WIDTH-1:0]       awaddr,
  input  logic [PLENGTH_WIDTH-1:0]     awlen,
  input  logic [PSIZE_WIDTH-1:0]       awsize,
  input  logic [PAWUSER_WIDTH-1:0]     awuser,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [PID_WIDTH-1:0]         wid,
  input  logic [PDATA_WIDTH*8-1:0]     wdata,
  input  logic [PDATA_WIDTH-1:0]       wstrb,
  input  logic                         wlast,
  input  logic                         wvalid,
  output logic                         wready,
  output logic [PID_WIDTH-1:0]         bid,
  output logic [1:0]                   bresp,
  output logic                         bvalid,
  input  logic                         bready,
  input  logic [$clog2(MEM_DEPTH)-1:0] rd_addr,
  output logic [PDATA_WIDTH*8-1:0]     rd_data
);

  localparam int ADDR_BITS  = $clog2(MEM_DEPTH);
  localparam int BYTE_SHIFT = $clog2(PDATA_WIDTH);
  localparam int DW         = PDATA_WIDTH * 8;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Captured address-phase attributes
  logic [PID_WIDTH-1:0]     id_q;
  logic [PADDR_WIDTH-1:0]   addr_q;
  logic [PLENGTH_WIDTH-1:0] len_q;
  logic [PSIZE_WIDTH-1:0]   size_q;
  logic [1:0]               burst_q;
  logic [PAWUSER_WIDTH-1:0] user_q;

  logic [PLENGTH_WIDTH-1:0] cnt_q;
  logic                     dec_err_q;
  logic                     slv_err_q;

  logic [DW-1:0] mem [MEM_DEPTH];

  logic                   aw_hs, w_hs, b_hs;
  logic                   burst_ok;
  logic                   last_beat;
  logic [PADDR_WIDTH-1:0] word_idx;
  logic                   in_range;
  logic                   id_ok;
  logic                   last_ok;
  logic                   mem_we;
  logic [ADDR_BITS-1:0]   mem_idx;
  logic                   unused_user;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign b_hs  = bvalid && bready;

  // An illegal burst is still drained beat-for-beat, it just never writes.
  assign burst_ok = (burst_q == BURST_INCR)
                 && (size_q == PSIZE_WIDTH'(BYTE_SHIFT))
                 && ((addr_q & PADDR_WIDTH'(PDATA_WIDTH - 1)) == '0);

  assign last_beat = (cnt_q == len_q);
  assign word_idx  = (addr_q >> BYTE_SHIFT) + PADDR_WIDTH'(cnt_q);
  assign in_range  = (word_idx < PADDR_WIDTH'(MEM_DEPTH));
  assign id_ok     = (wid == id_q);
  assign last_ok   = (wlast == last_beat);
  assign mem_we    = w_hs && burst_ok && in_range && id_ok;
  assign mem_idx   = word_idx[ADDR_BITS-1:0];

  assign unused_user = ^user_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (aw_hs) state_d = DATA;
      DATA:    if (w_hs && last_beat) state_d = RESP;
      RESP:    if (b_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bid     = '0;
    bresp   = RESP_OKAY;
    if (!rst) begin
      case (state_q)
        IDLE: awready = 1'b1;
        DATA: wready  = 1'b1;
        RESP: begin
          bvalid = 1'b1;
          bid    = id_q;
          if (dec_err_q)                   bresp = RESP_DECERR;
          else if (slv_err_q || !burst_ok) bresp = RESP_SLVERR;
          else                             bresp = RESP_OKAY;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      user_q    <= '0;
      cnt_q     <= '0;
      dec_err_q <= 1'b0;
      slv_err_q <= 1'b0;
    end else if (aw_hs) begin
      id_q      <= awid;
      addr_q    <= awaddr;
      len_q     <= awlen;
      size_q    <= awsize;
      burst_q   <= awburst;
      user_q    <= awuser;
      cnt_q     <= '0;
      dec_err_q <= 1'b0;
      slv_err_q <= 1'b0;
    end else if (w_hs) begin
      // Holding at awlen on the final beat keeps awlen=max from wrapping.
      if (!last_beat) cnt_q <= cnt_q + 1'b1;
      if (!in_range) dec_err_q <= 1'b1;
      if (!id_ok || !last_ok) slv_err_q <= 1'b1;
    end
  end

  // NOTE: the memory array has no reset; its contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < PDATA_WIDTH; k++) begin
        if (wstrb[k]) mem[mem_idx][k*8 +: 8] <= wdata[k*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_axi_wr_slave.sv
// Randomized self-checking bench for axi_wr_slave against a word-array
// reference model of the expected memory image and write responses.
module tb_axi_wr_slave;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  awburst = '0;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [3:0]  awuser = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [3:0]  wid = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [7:0]  rd_addr = '0;
  logic [31:0] rd_data;

  logic [31:0] model [DEPTH];
  int checks = 0;
  int errors = 0;

  axi_wr_slave dut (
    .clk(clk), .rst(rst),
    .awburst(awburst), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awuser(awuser), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_aw(input logic [31:0] addr, input int len, input logic [1:0] burst,
                         input logic [2:0] size, input logic [3:0] id);
    int n;
    awaddr = addr; awlen = 8'(len); awburst = burst; awsize = size; awid = id;
    awuser = 4'($urandom); awvalid = 1'b1;
    n = 0;
    while (!awready && n < 100) begin tick(); n++; end
    check("aw_ready", awready, 1'b1);
    tick();
    awvalid = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] s,
                           input logic [3:0] id, input logic last);
    int n;
    if ($urandom_range(0, 3) == 0) begin wvalid = 1'b0; tick(); end
    wdata = d; wstrb = s; wid = id; wlast = last; wvalid = 1'b1;
    n = 0;
    while (!wready && n < 100) begin tick(); n++; end
    check("w_ready", wready, 1'b1);
    tick();
    wvalid = 1'b0;
  endtask

  task automatic get_resp(input logic [3:0] exp_id, input logic [1:0] exp_resp, input int hold);
    int n;
    n = 0;
    while (!bvalid && n < 100) begin tick(); n++; end
    check("b_valid", bvalid, 1'b1);
    check("b_id", bid, exp_id);
    check("b_resp", bresp, exp_resp);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_bvalid", bvalid, 1'b1);
      check("hold_bid", bid, exp_id);
      check("hold_bresp", bresp, exp_resp);
      check("hold_awready", awready, 1'b0);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("b_drop", bvalid, 1'b0);
    check("aw_after_b", awready, 1'b1);
  endtask

  task automatic read_word(input int a, input logic [31:0] exp, input string tag);
    rd_addr = 8'(a);
    tick();
    check(tag, rd_data, exp);
  endtask

  task automatic verify(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) read_word(a, model[a], "mem");
  endtask

  // Reference: word index = addr/4 + n, bytes land only under strobe, only
  // for a legal burst, a matching wid and an index inside the memory.
  task automatic run_burst(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [3:0] id,
                           input longint seq_base, input int strb_sel,
                           input int bad_wid, input int early_last, input int hold);
    bit          legal, dec, slv, last;
    longint      idx;
    logic [31:0] d;
    logic [3:0]  s, wv;
    logic [1:0]  er;
    legal = (burst == 2'b01) && (size == 3'd2) && (addr % 4 == 0);
    dec = 1'b0;
    slv = !legal;
    send_aw(addr, len, burst, size, id);
    for (int n = 0; n <= len; n++) begin
      d    = (seq_base < 0) ? $urandom : 32'(seq_base + n);
      s    = (strb_sel < 0) ? 4'($urandom_range(0, 15)) : 4'(strb_sel);
      wv   = (n == bad_wid) ? (id ^ 4'h1) : id;
      last = (early_last >= 0) ? (n == early_last) : (n == len);
      if (wv != id || last != (n == len)) slv = 1'b1;
      idx = longint'(addr / 4) + n;
      if (idx >= DEPTH) dec = 1'b1;
      else if (legal && wv == id)
        for (int b = 0; b < 4; b++) if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
      send_beat(d, s, wv, last);
    end
    er = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
    get_resp(id, er, hold);
  endtask

  initial begin
    int w, len, bw, ea, lo, hi;
    logic [31:0] a;
    logic [1:0]  bt;
    logic [2:0]  sz;

    repeat (3) tick();
    check("rst_awready", awready, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_bid", bid, 4'h0);
    check("rst_bresp", bresp, 2'b00);
    check("rst_rd_data", rd_data, 32'h0);
    rst = 1'b0;
    #1;
    check("post_rst_awready", awready, 1'b1);
    check("post_rst_wready", wready, 1'b0);
    tick();

    // W before AW must stall
    wvalid = 1'b1; wid = 4'h2; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wlast = 1'b1;
    repeat (3) begin tick(); check("w_stall_idle", wready, 1'b0); end
    wvalid = 1'b0;

    // awlen = 255 fills the whole memory and gives the model a known image
    run_burst(32'h0, 255, 2'b01, 3'd2, 4'h0, -1, 15, -1, -1, 0);
    verify(0, DEPTH - 1);

    // Basic INCR burst with a stalled response
    run_burst(32'h10, 3, 2'b01, 3'd2, 4'h5, 32'hA0, 15, -1, -1, 5);
    for (int i = 0; i < 4; i++) read_word(4 + i, 32'hA0 + 32'(i), "incr_word");

    // Partial strobe over a known old value; same-cycle read returns old data
    run_burst(32'h0, 0, 2'b01, 3'd2, 4'h1, 32'h1122_3344, 15, -1, -1, 0);
    send_aw(32'h0, 0, 2'b01, 3'd2, 4'h6);
    rd_addr = 8'h0;
    send_beat(32'hDDCC_BBAA, 4'b0101, 4'h6, 1'b1);
    check("rd_old_data", rd_data, 32'h1122_3344);
    model[0] = 32'h11CC_33AA;
    get_resp(4'h6, 2'b00, 0);
    read_word(0, 32'h11CC_33AA, "strb_merge");

    // Burst running off the end of memory: no wrap, DECERR
    run_burst(32'h3F8, 3, 2'b01, 3'd2, 4'h7, -1, 15, -1, -1, 1);
    verify(0, DEPTH - 1);

    // Illegal burst type and premature wlast both give SLVERR
    run_burst(32'h20, 1, 2'b10, 3'd2, 4'h8, -1, 15, -1, -1, 0);
    run_burst(32'h30, 2, 2'b01, 3'd2, 4'h9, -1, 15, -1, 1, 0);
    verify(8, 14);

    // Reset mid-burst after two of four beats
    send_aw(32'h40, 3, 2'b01, 3'd2, 4'h3);
    for (int n = 0; n < 2; n++) begin
      model[16 + n] = 32'hC0DE_0000 + 32'(n);
      send_beat(32'hC0DE_0000 + 32'(n), 4'hF, 4'h3, 1'b0);
    end
    rst = 1'b1;
    #1;
    check("mid_rst_awready", awready, 1'b0);
    check("mid_rst_wready", wready, 1'b0);
    check("mid_rst_bvalid", bvalid, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("after_rst_awready", awready, 1'b1);
    check("after_rst_bvalid", bvalid, 1'b0);
    check("after_rst_bresp", bresp, 2'b00);
    check("after_rst_rd_data", rd_data, 32'h0);
    tick();
    check("after_rst_idle_bvalid", bvalid, 1'b0);
    verify(16, 19);
    run_burst(32'h40, 3, 2'b01, 3'd2, 4'h4, -1, 15, -1, -1, 0);
    verify(16, 19);

    // Randomized bursts: mostly legal, some malformed in assorted ways
    for (int t = 0; t < 40; t++) begin
      w   = $urandom_range(0, DEPTH - 1);
      len = $urandom_range(0, 7);
      bt  = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b01;
      sz  = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd2;
      a   = 32'(w * 4) + (($urandom_range(0, 9) == 0) ? 32'd2 : 32'd0);
      bw  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
      ea  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1;
      run_burst(a, len, bt, sz, 4'($urandom), -1, -1, bw, ea, $urandom_range(0, 3));
      lo = w;
      hi = (w + len > DEPTH - 1) ? DEPTH - 1 : w + len;
      verify(lo, hi);
    end
    verify(0, DEPTH - 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_wr_slave.md
AXI_WR_SLAVE -- requirements
Module: axi_wr_slave

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- PID_WIDTH, 4, ID width.
- PADDR_WIDTH, 32, byte address width.
- PLENGTH_WIDTH, 8, awlen width (beats-1).
- PSIZE_WIDTH, 3, awsize width.
- PAWUSER_WIDTH, 4, awuser width.
- PDATA_WIDTH, 4, data bytes per beat (power of 2).
- MEM_DEPTH, 256, internal words (power of 2).
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock.
- rst, in, 1, reset (synchronous, active-high).
- awburst, in, 2, burst type.
- awid, in, PID_WIDTH, write ID.
- awaddr, in, PADDR_WIDTH, start byte address.
- awlen, in, PLENGTH_WIDTH, beats-1.
- awsize, in, PSIZE_WIDTH, log2 bytes per beat.
- awuser, in, PAWUSER_WIDTH, user sideband (captured, unused).
- awvalid, in, 1, address valid.
- awready, out, 1, address ready.
- wid, in, PID_WIDTH, data ID.
- wdata, in, PDATA_WIDTH x 8, beat data (byte-packed).
- wstrb, in, PDATA_WIDTH, byte enables.
- wlast, in, 1, last beat.
- wvalid, in, 1, data valid.
- wready, out, 1, data ready.
- bid, out, PID_WIDTH, response ID.
- bresp, out, 2, response code.
- bvalid, out, 1, response valid.
- bready, in, 1, response ready.
- rd_addr, in, log2(MEM_DEPTH), backdoor word read address.
- rd_data, out, PDATA_WIDTH x 8, backdoor read data.
REQ-003 Clock is clk; reset is rst, synchronous and active-high; all state changes on rising clk.

Function
REQ-004 FSM states are IDLE, DATA and RESP; reset state is IDLE.
REQ-005 IDLE: awready=1, wready=0, bvalid=0; on awvalid&awready, capture awid/awaddr/awlen/awsize/awburst/awuser, clear beat counter and error flags, go to DATA.
REQ-006 DATA: awready=0, wready=1; each wvalid&wready is one beat.
REQ-007 Word index for beat n is (awaddr/PDATA_WIDTH)+n, computed PADDR_WIDTH wide with no modulo.
REQ-008 A beat writes byte k of wdata to byte k of mem[index] only where wstrb[k]=1, and only if the burst is legal (REQ-010) and the index is < MEM_DEPTH.
REQ-009 Beat with index >= MEM_DEPTH: no write, set decode-error flag; no wrap to word 0.
REQ-010 Slave-error flag is set if any of the following holds; when set, no beat of the burst is written:
- awburst != 2'b01;
- awsize != log2(PDATA_WIDTH);
- awaddr is not PDATA_WIDTH-aligned.
REQ-011 Slave-error flag is set on a beat where wid != captured awid (that beat is not written), or where wlast disagrees with (counter == awlen).
REQ-012 Burst ends on the beat where counter == awlen regardless of wlast; next state is RESP; transfer is exactly awlen+1 beats.
REQ-013 RESP: bvalid=1, bid=captured awid, and bresp set by priority: 2'b11 (DECERR) if decode flag, else 2'b10 (SLVERR) if slave flag, else 2'b00 (OKAY); outputs held stable until bready.
REQ-014 On bvalid&bready go to IDLE; a new AW is accepted no earlier than the cycle after the handshake.
REQ-015 One outstanding transaction; no W beat accepted in IDLE or RESP (W before AW stalls).
REQ-016 rd_data = mem[rd_addr] registered, 1-cycle latency; a same-cycle write to rd_addr returns old data.
REQ-017 awlen = max (255) is supported with no counter overflow.

Reset
REQ-018 rst in any state -> IDLE next cycle; awready, wready and bvalid drop to 0 the cycle rst is sampled; bid and bresp reset to 0; in-flight burst discarded with no response.
REQ-019 Memory contents are not cleared by rst; rd_data resets to 0.
REQ-020 After rst deasserts, awready=1 in the first cycle.

Verification
REQ-021 AW addr 0x10, len 3, size 2, INCR, id 5; 4 beats 0xA0..0xA3, strb 0xF, wlast on 4th -> mem[4..7]=0xA0..0xA3, bid=5, bresp=00.
REQ-022 Single beat to addr 0x0, strb 4'b0101, data 0xDDCCBBAA over old 0x11223344 -> mem[0]=0x11CC33AA, OKAY.
REQ-023 AW addr 0x3F8 (word 254), len 3 -> words 254 and 255 written, beats 3-4 dropped, bresp=11.
REQ-024 awburst=2'b10, len 1 -> 2 beats accepted, no writes, bresp=10; wlast on beat 1 of len 2 -> bresp=10.
REQ-025 bready held 0 for 5 cycles -> bvalid/bid/bresp stable, awready=0 throughout; handshake then awready=1 the next cycle.
REQ-026 rst asserted mid-burst after beat 2 of 4 -> no bvalid, IDLE, beats 1-2 remain in memory, next burst completes OKAY.
